bresenham_line: RTL
===================

# bresenham_line

Line rasteriser downstream of the ADC-to-coordinate converter in the oscilloscope trace path. It accepts one segment (x0,y0)→(x1,y1) per start pulse and walks it with integer Bresenham stepping. It emits one framebuffer pixel write per accepted handshake, drops off-screen points, and pulses `done` so the converter can issue the next segment.

## Interface
- `H_RES`, 640: visible width; pixels with x ≥ H_RES are suppressed.
- `V_RES`, 480: visible height; pixels with y ≥ V_RES are suppressed.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle segment request; sampled only in IDLE.
- `x0`, `y0`, `x1`, `y1`  in  10 each  segment endpoints, unsigned; sampled on the `start` cycle.
- `pixel_x`  out  10  pixel column.
- `pixel_y`  out  10  pixel row.
- `pixel_valid`  out  1  a pixel write is offered.
- `pixel_ready`  in  1  framebuffer accepts the pixel.
- `busy`  out  1  segment in progress.
- `done`  out  1  one-cycle pulse after the last point of a segment.

## Operation
- States: IDLE, SETUP, PLOT, FINISH.
- **IDLE**
  - `start`=1 latches the endpoints and moves to SETUP.
  - `busy` goes high the next cycle.
- **SETUP** (1 cycle) computes:
  - dx = |x1−x0|, dy = −|y1−y0|
  - sx = (x0<x1) ? +1 : −1, sy = (y0<y1) ? +1 : −1
  - err = dx+dy
  - (x,y) = (x0,y0)
  - Then moves to PLOT.
- **PLOT**, current point (x,y):
  - On-screen (x<H_RES and y<V_RES): `pixel_valid`=1 with `pixel_x`/`pixel_y`=(x,y). The point advances only on `pixel_valid && pixel_ready`.
  - Off-screen: `pixel_valid`=0 and the point advances unconditionally that cycle.
  - Advance rule:
    - If (x,y)=(x1,y1), go to FINISH.
    - Otherwise e2 = 2·err.
    - If e2 ≥ dy: err += dy, x += sx.
    - If e2 ≤ dx: err += dx, y += sy.
    - Both updates apply in the same cycle using the pre-update err.
- **FINISH** (1 cycle): `done`=1, `busy`=0, return to IDLE.
- Arithmetic widths:
  - dx, dy: 11-bit signed.
  - err: 12-bit signed.
  - e2: 13-bit signed.
  - x, y: 10-bit unsigned. They never leave [min,max] of the endpoints, so no wrap-around.
- Point count N = max(dx, −dy)+1, inclusive of both endpoints.
- Degenerate segment (x0=x1, y0=y1): exactly one point, then `done`.
- `start` outside IDLE is ignored; the in-flight segment is unaffected.
- `pixel_x`/`pixel_y` are held stable while `pixel_valid`=1 and `pixel_ready`=0.
- `pixel_valid` never drops without a handshake.
- Reset mid-segment aborts immediately: no `done` and no further pixels.

## Timing
- Reset values: state IDLE; `pixel_valid`=0, `pixel_x`=0, `pixel_y`=0, `busy`=0, `done`=0.
- `start` high at edge k:
  - SETUP during cycle k+1.
  - First `pixel_valid` during cycle k+2.
- With `pixel_ready` held at 1: one point per cycle, so the segment completes in N+2 cycles after `start`.
- Last point handshaken (or skipped) at edge m: `done`=1 during cycle m+1, and `busy` is low in that same cycle.
- Earliest next `start` is accepted at edge m+2, giving a 1-cycle gap in IDLE.
- Each stalled cycle (`pixel_ready`=0 with `pixel_valid`=1) adds exactly one cycle.
- Each off-screen point costs exactly one cycle.

## Structure
- A shared package `osc_pkg` holds:
  - H_RES/V_RES defaults (640/480), also used by the converter and framebuffer.
  - COORD_W=10.
  - ERR_W=12.
  - The state encoding.
- Single module with no sub-module. The step logic is one combinational block feeding the PLOT registers.

## Test plan
- Horizontal segment (0,240)→(1,240), `pixel_ready`=1 → pixels (0,240) then (1,240) on consecutive cycles; `done` 4 cycles after `start`.
- Steep segment (5,10)→(6,200) → 191 pixels, first (5,10), last (6,200); x=5 through (5,104); first x=6 pixel is (6,105); no x/y gaps.
- Degenerate (7,7)→(7,7) → single pixel (7,7); `done` in cycle k+3.
- Clipping (10,470)→(11,500) → exactly 10 pixels, y 470..479; `done` after 31 point cycles; no `pixel_valid` for y ≥ 480.
- Backpressure: (0,0)→(3,3) with `pixel_ready` toggling 1,0,0,1,… → all 4 pixels appear in order; coordinates stable during stalls; `start` pulses while `busy` are ignored.
- Reset: assert `reset_n`=0 mid-way through (0,0)→(100,50) → outputs return to reset values asynchronously; no `done`; a new `start` after release draws correctly from its own x0,y0.

Source files
------------

// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscilloscope trace path: visible screen size
// (also used by the coordinate converter and the framebuffer), coordinate
// and error-term widths, and the line rasteriser state encoding.
// ---------------------------------------------------------------------------
package osc_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int COORD_W   = 10;
    localparam int ERR_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_PLOT   = 2'd2,
        ST_FINISH = 2'd3
    } line_state_e;

endpackage

// File: rtl/bresenham_line.sv
// ---------------------------------------------------------------------------
// bresenham_line
// Walks one segment (x0,y0)->(x1,y1) per start pulse with integer Bresenham
// stepping and offers each on-screen point as a framebuffer pixel write.
// Off-screen points are skipped at one cycle each; done pulses once after
// the last point.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle segment request (honoured only in IDLE)
//   x0, y0, x1, y1        segment endpoints, latched on the start cycle
//   pixel_x, pixel_y      current pixel coordinate (registered)
//   pixel_valid           pixel write offered (registered)
//   pixel_ready           framebuffer accepts the pixel
//   busy                  segment in progress (registered)
//   done                  one-cycle pulse after the last point (registered)
// ---------------------------------------------------------------------------
module bresenham_line
    import osc_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic               busy,
    output logic               done
);

    line_state_e               state_r;
    logic [COORD_W-1:0]        x0_r, y0_r, x1_r, y1_r;
    logic [COORD_W-1:0]        x_r, y_r;
    logic signed [COORD_W:0]   dx_r, dy_r;
    logic                      sx_neg_r, sy_neg_r;
    logic signed [ERR_W-1:0]   err_r;
    logic [COORD_W-1:0]        pixel_x_r, pixel_y_r;
    logic                      pixel_valid_r, busy_r, done_r;

    logic [COORD_W-1:0]        dx_abs_s, dy_abs_s;
    logic signed [COORD_W:0]   setup_dx_s, setup_dy_s;
    logic signed [ERR_W-1:0]   setup_err_s;

    logic signed [ERR_W:0]     e2_s, dx_ext_s, dy_ext_s;
    logic                      x_step_s, y_step_s, at_end_s, advance_s;
    logic signed [ERR_W-1:0]   err_next_s;
    logic [COORD_W-1:0]        x_next_s, y_next_s;

    // A point is drawable only inside the visible window.
    function automatic logic on_screen(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py);
        return (int'(px) < H_RES) && (int'(py) < V_RES);
    endfunction

    // Segment setup terms from the latched endpoints: dx >= 0, dy <= 0.
    always_comb begin
        dx_abs_s    = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
        dy_abs_s    = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
        setup_dx_s  = {1'b0, dx_abs_s};
        setup_dy_s  = 11'sd0 - $signed({1'b0, dy_abs_s});
        setup_err_s = {setup_dx_s[COORD_W], setup_dx_s} + {setup_dy_s[COORD_W], setup_dy_s};
    end

    // One Bresenham step; both axis updates use the pre-update error term.
    always_comb begin
        e2_s       = {err_r, 1'b0};
        dx_ext_s   = {{2{dx_r[COORD_W]}}, dx_r};
        dy_ext_s   = {{2{dy_r[COORD_W]}}, dy_r};
        x_step_s   = (e2_s >= dy_ext_s);
        y_step_s   = (e2_s <= dx_ext_s);
        at_end_s   = (x_r == x1_r) && (y_r == y1_r);
        // Off-screen points carry pixel_valid=0 and so advance unconditionally.
        advance_s  = (state_r == ST_PLOT) && (!pixel_valid_r || pixel_ready);
        err_next_s = err_r;
        x_next_s   = x_r;
        y_next_s   = y_r;
        if (x_step_s) begin
            err_next_s = err_next_s + {dy_r[COORD_W], dy_r};
            x_next_s   = sx_neg_r ? (x_r - 10'd1) : (x_r + 10'd1);
        end else begin
            x_next_s   = x_r;
        end
        if (y_step_s) begin
            err_next_s = err_next_s + {dx_r[COORD_W], dx_r};
            y_next_s   = sy_neg_r ? (y_r - 10'd1) : (y_r + 10'd1);
        end else begin
            y_next_s   = y_r;
        end
    end

    // Control FSM and all registered state/outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            x0_r          <= 10'd0;
            y0_r          <= 10'd0;
            x1_r          <= 10'd0;
            y1_r          <= 10'd0;
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            dx_r          <= 11'sd0;
            dy_r          <= 11'sd0;
            sx_neg_r      <= 1'b0;
            sy_neg_r      <= 1'b0;
            err_r         <= 12'sd0;
            pixel_x_r     <= 10'd0;
            pixel_y_r     <= 10'd0;
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x0_r    <= x0;
                        y0_r    <= y0;
                        x1_r    <= x1;
                        y1_r    <= y1;
                        busy_r  <= 1'b1;
                        state_r <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    dx_r          <= setup_dx_s;
                    dy_r          <= setup_dy_s;
                    sx_neg_r      <= !(x0_r < x1_r);
                    sy_neg_r      <= !(y0_r < y1_r);
                    err_r         <= setup_err_s;
                    x_r           <= x0_r;
                    y_r           <= y0_r;
                    pixel_x_r     <= x0_r;
                    pixel_y_r     <= y0_r;
                    pixel_valid_r <= on_screen(x0_r, y0_r);
                    state_r       <= ST_PLOT;
                end
                ST_PLOT: begin
                    if (advance_s && at_end_s) begin
                        pixel_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        state_r       <= ST_FINISH;
                    end else if (advance_s) begin
                        err_r         <= err_next_s;
                        x_r           <= x_next_s;
                        y_r           <= y_next_s;
                        pixel_x_r     <= x_next_s;
                        pixel_y_r     <= y_next_s;
                        pixel_valid_r <= on_screen(x_next_s, y_next_s);
                    end else begin
                        // Stalled: hold the offered pixel unchanged.
                        state_r       <= ST_PLOT;
                    end
                end
                ST_FINISH: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    pixel_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign pixel_x     = pixel_x_r;
    assign pixel_y     = pixel_y_r;
    assign pixel_valid = pixel_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
